// File: rtl/dct_mac_pipe.sv
// Pipelined signed MAC: accumulates framed groups of din0*din1 taps and emits one scaled result per group.
// Latency: dout_vld MUL_STAGE+2 ce-enabled edges after the edge accepting the group's last tap.
// Backpressure: none; ce=0 freezes every register. Optional DCT_MAC_ROUND_SAT_EN selects round+saturate scaling.
module dct_mac_pipe #(
  parameter int DIN0_WIDTH = 15,
  parameter int DIN1_WIDTH = 16,
  parameter int ACC_WIDTH  = 34,
  parameter int DOUT_WIDTH = 16,
  parameter int SHIFT      = 13,
  parameter int MUL_STAGE  = 2,
  parameter int MAX_TAPS   = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                ce,
  input  logic signed [DIN0_WIDTH-1:0]        din0,
  input  logic signed [DIN1_WIDTH-1:0]        din1,
  input  logic                                din_vld,
  input  logic                                din_last,
  output logic signed [DOUT_WIDTH-1:0]        dout,
  output logic                                dout_vld,
  output logic [$clog2(MAX_TAPS+1)-1:0]       tap_cnt,
  output logic                                err
);

  localparam int CW = $clog2(MAX_TAPS+1);
  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LS = MUL_STAGE - 1;

  // input register stage
  logic signed [DIN0_WIDTH-1:0] in0_q;
  logic signed [DIN1_WIDTH-1:0] in1_q;
  logic                         in_vld, in_last, in_first;

  // group framing: a tap opens a group when nothing has been counted yet,
  // and closes it on din_last or when it is the MAX_TAPS-th tap
  logic tap_first, tap_full, tap_end;
  assign tap_first = (tap_cnt == '0);
  assign tap_full  = (tap_cnt == CW'(MAX_TAPS - 1));
  assign tap_end   = din_last | tap_full;

  // full-precision product, sign-extended into the accumulator domain
  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  assign prod     = in0_q * in1_q;
  assign prod_ext = ACC_WIDTH'(prod);

  // product pipe with its framing flags
  logic signed [ACC_WIDTH-1:0] pp [MUL_STAGE];
  logic [MUL_STAGE-1:0]        pv, pl, pf;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic                         acc_done;
  logic signed [DOUT_WIDTH-1:0] scaled;

  // capture taps and track group framing / sticky overflow error
  always_ff @(posedge clk) begin
    if (reset) begin
      in0_q    <= '0;
      in1_q    <= '0;
      in_vld   <= 1'b0;
      in_last  <= 1'b0;
      in_first <= 1'b0;
      tap_cnt  <= '0;
      err      <= 1'b0;
    end else if (ce) begin
      in0_q    <= din0;
      in1_q    <= din1;
      in_vld   <= din_vld;
      in_last  <= din_vld & tap_end;
      in_first <= din_vld & tap_first;
      if (din_vld) begin
        tap_cnt <= tap_end ? '0 : tap_cnt + CW'(1);
        if (tap_full && !din_last) err <= 1'b1;
      end
    end
  end

  // shift products and flags through MUL_STAGE registers
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_STAGE; i++) pp[i] <= '0;
      pv <= '0;
      pl <= '0;
      pf <= '0;
    end else if (ce) begin
      pp[0] <= prod_ext;
      pv[0] <= in_vld;
      pl[0] <= in_last;
      pf[0] <= in_first;
      for (int i = 1; i < MUL_STAGE; i++) begin
        pp[i] <= pp[i-1];
        pv[i] <= pv[i-1];
        pl[i] <= pl[i-1];
        pf[i] <= pf[i-1];
      end
    end
  end

  // accumulate (wrapping); first tap of a group overwrites the accumulator
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      acc_done <= 1'b0;
    end else if (ce) begin
      acc_done <= pv[LS] & pl[LS];
      if (pv[LS]) acc <= pf[LS] ? pp[LS] : acc + pp[LS];
    end
  end

`ifdef DCT_MAC_ROUND_SAT_EN
  // round half toward +inf at ACC_WIDTH+1 bits, then clamp to the output range
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_WIDTH:0] RND = (SHIFT > 0) ? ((ACC_WIDTH+1)'(1) <<< RSH) : '0;
  logic signed [ACC_WIDTH:0] rsum, rshr;
  logic                      fits;
  assign rsum   = {acc[ACC_WIDTH-1], acc} + RND;
  assign rshr   = rsum >>> SHIFT;
  assign fits   = (&rshr[ACC_WIDTH:DOUT_WIDTH-1]) | ~(|rshr[ACC_WIDTH:DOUT_WIDTH-1]);
  assign scaled = fits ? rshr[DOUT_WIDTH-1:0]
                       : {rshr[ACC_WIDTH], {(DOUT_WIDTH-1){~rshr[ACC_WIDTH]}}};
`else
  // floor shift, then two's-complement truncation
  assign scaled = DOUT_WIDTH'(acc >>> SHIFT);
`endif

  // register the scaled result one edge after the group's last accumulation
  always_ff @(posedge clk) begin
    if (reset) begin
      dout     <= '0;
      dout_vld <= 1'b0;
    end else if (ce) begin
      dout_vld <= acc_done;
      if (acc_done) dout <= scaled;
    end
  end

endmodule

// File: doc/dct_mac_pipe.md
Name: dct_mac_pipe

Overview:
- Pipelined, parametrised signed multiply-accumulate unit; successor to the single-cycle 15s x 16s DSP multiplier wrapper used inside the DCT datapath.
- Accepts a stream of (coefficient, sample) pairs grouped into dot products of up to MAX_TAPS taps. Emits one scaled result per group.
- Replaces the HLS multiply-then-adder-tree path in the DCT row/column kernels. Gives a stall-able (ce) pipeline with group framing and overflow handling.

Parameters:
- DIN0_WIDTH, 15: signed coefficient width.
- DIN1_WIDTH, 16: signed sample width.
- ACC_WIDTH, 34: signed accumulator width. Must be >= DIN0_WIDTH + DIN1_WIDTH + clog2(MAX_TAPS).
- DOUT_WIDTH, 16: signed result width.
- SHIFT, 13: arithmetic right shift applied to the accumulator at output (Q13 coefficients). Legal range 0..ACC_WIDTH-1.
- MUL_STAGE, 2: product register stages, >= 1.
- MAX_TAPS, 8: maximum taps per group.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; when 0, every register holds its value.
- din0  in  DIN0_WIDTH  signed coefficient.
- din1  in  DIN1_WIDTH  signed sample.
- din_vld  in  1  tap valid; sampled only when ce=1.
- din_last  in  1  marks final tap of group; qualified by din_vld.
- dout  out  DOUT_WIDTH  scaled group result, registered.
- dout_vld  out  1  one-cycle (ce-qualified) pulse; dout valid.
- tap_cnt  out  clog2(MAX_TAPS+1)  taps accepted so far in the current input-side group.
- err  out  1  sticky; set when a group reaches MAX_TAPS without din_last.

Behaviour:
- Reset (clk edge with reset=1, regardless of ce): dout=0, dout_vld=0, tap_cnt=0, err=0. Accumulator=0. All pipeline valid/last/first flags cleared. In-flight taps are discarded and produce no dout_vld.
- Accept: a tap is accepted on an edge with ce=1, din_vld=1, reset=0. No backpressure; ce is the only stall.
- Product: full-precision signed din0*din1 (DIN0_WIDTH+DIN1_WIDTH bits), sign-extended to ACC_WIDTH. It passes through MUL_STAGE registers together with its vld, last and first flags.
- Accumulate: at the stage after the product pipe, for each valid product:
  - first=1: acc <= product.
  - otherwise: acc <= acc + product.
  - Arithmetic wraps modulo 2^ACC_WIDTH. No internal saturation.
- first flag: set on the first tap after reset or after a group end (explicit or implicit).
- Output: on the edge after the last product is accumulated, dout <= scale(acc_final) and dout_vld <= 1. dout_vld is 0 on every other ce-enabled edge. dout holds its value between pulses.
- Latency: dout_vld rises MUL_STAGE+2 ce-enabled edges after the edge accepting the last tap; default 4. Stalled cycles add 1:1.
- Throughput: one tap per cycle. Back-to-back groups with no bubble are supported; the first tap of group N+1 may be accepted on the edge after last of group N.
- A single-tap group (din_last on the first tap) is legal.
- tap_cnt: increments per accepted tap and returns to 0 on the edge accepting a group-end tap.
- Implicit end: if the MAX_TAPS-th tap of a group arrives with din_last=0:
  - the tap is treated as last;
  - err <= 1 (sticky until reset);
  - the next tap starts a new group.
- din_last with din_vld=0 is ignored.
- Scale (default build): dout = (acc >>> SHIFT)[DOUT_WIDTH-1:0]. This is floor division, then two's-complement truncation.

Optional Feature:
- Macro: DCT_MAC_ROUND_SAT_EN.
- Defined: dout = sat((acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT), i.e. round half toward +inf.
  - sat clamps to [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1].
  - The rounding add is computed at ACC_WIDTH+1 bits, so it cannot wrap.
  - Latency is unchanged.
- Undefined: floor plus truncation as above. No rounding or saturation logic is synthesised.

Test Plan:
1. 8 taps din0=8192, din1=100, last on tap 8, ce=1 -> one dout_vld pulse 4 edges after the last tap; dout=800; tap_cnt returns to 0; err=0.
2. Single tap din0=4096, din1=3 (acc 12288), then single tap din0=-4096, din1=3 -> default build: dout=1, then -2; with DCT_MAC_ROUND_SAT_EN: dout=2, then -1.
3. 8 taps din0=16383, din1=32767 (acc 4294574088) -> default: dout=-48 (0xFFD0); with macro: dout=32767. Repeat with din0=-16384, din1=32767 -> with macro: dout=-32768.
4. Case 1 with ce=0 held for 3 cycles after tap 4, din inputs toggling randomly during the stall -> dout=800; dout_vld arrives 3 edges later than case 1; no spurious pulse.
5. 9 taps din0=1, din1=1, din_last never asserted, then tap 10 with last -> dout=0 (8>>>13) pulse after tap 8; err=1 and stays 1; a second pulse for the taps 9-10 group (acc=2).
6. Reset asserted for 1 cycle after tap 5 of a group, then a fresh 2-tap group (din0=8192, din1=5, 7) -> no pulse for the aborted group; the next pulse has dout=12; err=0.
